// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the NOP word shown on reset, and the bit positions of the decode fields.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT_LSB  = 12;
    localparam int FUNCT_MSB  = 14;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with a flush input. The head word is
// read straight from storage, so the outputs depend only on registers.
// Push and pop in the same cycle are both honoured, also when full.
module fetch_fifo #(
    parameter int               DEPTH      = 2,
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic                    not_empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign do_push   = push && ((count != FULL_CNT) || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; clear drops everything buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_WORD;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word fetches to instruction memory, buffers
// in-order responses in fetch_fifo, and flushes stale responses on redirect.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises if_misalign; otherwise the target is forced word aligned).
//
// Handshakes: imem_req/imem_gnt transfer a request on a cycle where both are
// high, and imem_addr is held while imem_req waits for a grant. if_valid/
// if_ready transfer the head instruction on a cycle where both are high.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         if_ready,
    output logic         if_valid,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc,
    output logic [6:0]   if_opcode,
    output logic [2:0]   if_funct,
    output logic         if_misalign,
    output fetch_state_t dbg_state
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = FIFO_DEPTH[CNT_W-1:0];

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      halt_pc;
    logic [31:0]      target;
    logic             target_bad;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_nxt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] in_flight;
    logic             grant;
    logic             rsp;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;
    logic [63:0]      head;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign target_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign target     = {redirect_pc[31:2], 2'b00};
    assign target_bad = 1'b0;
`endif

    assign grant = imem_req && imem_gnt;
    assign rsp   = imem_rvalid && (outstanding != '0);
    assign pop   = fifo_nonempty && if_ready && (state != ST_HALT);
    assign push  = rsp && (state == ST_RUN) && !redirect;
    // Slots already committed; a head leaving this cycle frees its slot at
    // the same edge, which keeps a depth-2 buffer streaming at full rate.
    assign in_flight = outstanding + fifo_count - {{(CNT_W-1){1'b0}}, pop};

    // Next state, stale-response budget and request issue.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        imem_req  = 1'b0;
        if (redirect) begin
            // Everything still in flight belongs to the old path.
            drop_nxt = outstanding - {{(CNT_W-1){1'b0}}, rsp};
            if (target_bad)
                state_nxt = ST_HALT;
            else if (drop_nxt != '0)
                state_nxt = ST_FLUSH;
            else
                state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    imem_req = !reset && (in_flight < DEPTH_CNT);
                end
                ST_FLUSH: begin
                    imem_req = !reset && (in_flight < DEPTH_CNT);
                    if (rsp) begin
                        drop_nxt = drop_cnt - 1'b1;
                        if (drop_nxt == '0) state_nxt = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (rsp && (drop_cnt != '0)) drop_nxt = drop_cnt - 1'b1;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM state, fetch/response PCs and in-flight bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            halt_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            case ({grant, rsp})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (redirect && !target_bad)
                fetch_pc <= target;
            else if (grant)
                fetch_pc <= fetch_pc + 32'd4;
            // Responses arrive in order, so the next kept one follows rsp_pc.
            if (redirect && !target_bad)
                rsp_pc <= target;
            else if (push)
                rsp_pc <= rsp_pc + 32'd4;
            if (redirect && target_bad)
                halt_pc <= redirect_pc;
        end
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .WIDTH      (64),
        .RESET_WORD ({RESET_PC, NOP_INSTR})
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({rsp_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head),
        .not_empty (fifo_nonempty),
        .count     (fifo_count)
    );

    assign imem_addr = fetch_pc;
    assign if_valid  = fifo_nonempty && (state != ST_HALT);
    assign if_instr  = head[31:0];
    assign if_pc     = (state == ST_HALT) ? halt_pc : head[63:32];
    assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign if_funct  = if_instr[FUNCT_MSB:FUNCT_LSB];
    assign dbg_state = state;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign if_misalign = (state == ST_HALT);
`else
    assign if_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: an in-order instruction memory with random grant and
// latency, a PC-sequence model of the fetch stream, and directed scenarios.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         if_ready = 1'b0;
    logic         if_valid;
    logic [31:0]  if_instr;
    logic [31:0]  if_pc;
    logic [6:0]   if_opcode;
    logic [2:0]   if_funct;
    logic         if_misalign;
    fetch_state_t dbg_state;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_ready    (if_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_opcode   (if_opcode),
        .if_funct    (if_funct),
        .if_misalign (if_misalign),
        .dbg_state   (dbg_state)
    );

    // ---------------- memory model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_txn_t;

    mem_txn_t mem_q[$];
    int       cyc = 0;
    int       last_due = 0;
    int       lat_min = 1;
    int       lat_max = 1;
    bit       gnt_rand = 1'b0;

    // ---------------- scoreboard / model state ----------------
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_addr;
    logic [31:0] halt_target;
    bit          halted = 1'b0;
    bit          exp_invalid = 1'b0;
    bit          saw_pc_zero = 1'b0;
    int          pops = 0;
    logic [31:0] cmp_w;
    logic [31:0] rtgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: present decode/redirect inputs and the memory response
    // at the falling edge, then grant against the settled request.
    task automatic tick(input bit rdy, input bit redir, input logic [31:0] rpc);
        int lat;
        int due;
        @(negedge clk);
        reset       = 1'b0;
        if_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            mem_q.delete(0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (imem_req && imem_gnt) begin
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_addr, due: due});
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        if_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        mem_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_pc", if_pc, RESET_PC);
        check("rst_misalign", if_misalign, 1'b0);
        model_pc    = RESET_PC;
        exp_addr    = RESET_PC;
        halted      = 1'b0;
        exp_invalid = 1'b0;
        last_due    = cyc;
    endtask

    // Hold decode off until the head is valid, then check its PC.
    task automatic wait_valid(input logic [31:0] pc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (if_valid) begin
                seen = 1'b1;
                check(name, if_pc, pc);
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no if_valid in 60 cycles, expected pc %h", name, pc);
        end
    endtask

    task automatic wait_outstanding(input int n, input string name);
        for (int i = 0; i < 30 && mem_q.size() != n; i++) tick(1'b1, 1'b0, 32'h0);
        check(name, mem_q.size(), n);
    endtask

    // ---------------- compare process ----------------
    // Checks every cycle against the fetch-stream model: requests walk
    // sequential word addresses from the last target, and accepted
    // instructions walk the same PC sequence with the memory's word.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (halted) begin
                check("halt_misalign", if_misalign, 1'b1);
                check("halt_req", imem_req, 1'b0);
                check("halt_valid", if_valid, 1'b0);
                check("halt_pc", if_pc, halt_target);
            end else begin
                check("misalign_low", if_misalign, 1'b0);
            end
            if (exp_invalid) check("valid_after_redirect", if_valid, 1'b0);
            exp_invalid = 1'b0;
            check("budget", mem_q.size() <= FIFO_DEPTH, 1'b1);
            if (redirect) begin
                check("req_in_redirect", imem_req, 1'b0);
            end else if (imem_req) begin
                check("req_addr", imem_addr, exp_addr);
                if (imem_gnt) exp_addr = exp_addr + 32'd4;
            end
            if (if_valid && if_ready) begin
                cmp_w = mem_word(model_pc);
                check("if_pc", if_pc, model_pc);
                check("if_instr", if_instr, cmp_w);
                check("if_opcode", if_opcode, cmp_w[6:0]);
                check("if_funct", if_funct, cmp_w[14:12]);
                if (model_pc == 32'h0 && if_pc == 32'h0) saw_pc_zero = 1'b1;
                model_pc = model_pc + 32'd4;
                pops++;
            end
            if (redirect) begin
                rtgt = redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (rtgt[1:0] != 2'b00) begin
                    halted      = 1'b1;
                    halt_target = rtgt;
                end else begin
                    halted   = 1'b0;
                    model_pc = rtgt;
                    exp_addr = rtgt;
                end
`else
                rtgt[1:0] = 2'b00;
                model_pc  = rtgt;
                exp_addr  = rtgt;
`endif
                exp_invalid = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          p0;
        bit          rdy;
        bit          redir;
        logic [31:0] tgt;

        // Streaming with a 1-cycle memory: first request right after reset,
        // instructions 0, 4, 8 back to back from the third cycle.
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
        do_reset();
        tick(1'b1, 1'b0, 32'h0);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RESET_PC);
        tick(1'b1, 1'b0, 32'h0);
        check("c1_no_valid", if_valid, 1'b0);
        tick(1'b1, 1'b0, 32'h0);
        check("c2_valid", if_valid, 1'b1);
        check("c2_pc", if_pc, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        check("c3_pc", if_pc, 32'h4);
        tick(1'b1, 1'b0, 32'h0);
        check("c4_pc", if_pc, 32'h8);
        repeat (15) tick(1'b1, 1'b0, 32'h0);

        // Decode stall: buffer fills, requests stop, nothing is lost.
        repeat (10) tick(1'b0, 1'b0, 32'h0);
        check("stall_req_off", imem_req, 1'b0);
        check("stall_valid", if_valid, 1'b1);
        check("stall_outstanding", mem_q.size(), 0);
        repeat (20) tick(1'b1, 1'b0, 32'h0);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        wait_outstanding(2, "outstanding_before_redirect");
        tick(1'b1, 1'b1, 32'h100);
        tick(1'b1, 1'b0, 32'h0);
        check("flush_state", dbg_state, ST_FLUSH);
        wait_valid(32'h100, "first_after_redirect");
        repeat (12) tick(1'b1, 1'b0, 32'h0);

        // Second redirect while still flushing.
        wait_outstanding(2, "outstanding_before_redirect2");
        tick(1'b1, 1'b1, 32'h180);
        tick(1'b1, 1'b1, 32'h200);
        check("flush_state2", dbg_state, ST_FLUSH);
        wait_valid(32'h200, "first_after_redirect2");
        repeat (12) tick(1'b1, 1'b0, 32'h0);

        // Fetch address wraps past the top of the address space.
        lat_min = 1; lat_max = 1;
        tick(1'b1, 1'b1, 32'hFFFF_FFF8);
        wait_valid(32'hFFFF_FFF8, "wrap_first");
        saw_pc_zero = 1'b0;
        repeat (10) tick(1'b1, 1'b0, 32'h0);
        check("wrap_to_zero", saw_pc_zero, 1'b1);

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
        tick(1'b1, 1'b1, 32'h102);
        tick(1'b1, 1'b0, 32'h0);
        check("misalign_flag", if_misalign, 1'b1);
        check("misalign_no_req", imem_req, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h200);
        wait_valid(32'h200, "resume_after_halt");
`else
        tick(1'b1, 1'b1, 32'h102);
        tick(1'b1, 1'b0, 32'h0);
        check("misalign_tied_low", if_misalign, 1'b0);
        wait_valid(32'h100, "forced_align");
`endif
        repeat (8) tick(1'b1, 1'b0, 32'h0);

        // Reset in the middle of traffic abandons everything in flight.
        lat_min = 2; lat_max = 2;
        tick(1'b1, 1'b1, 32'h400);
        repeat (3) tick(1'b1, 1'b0, 32'h0);
        do_reset();
        tick(1'b1, 1'b0, 32'h0);
        check("midreset_addr", imem_addr, RESET_PC);
        wait_valid(RESET_PC, "after_midreset");
        repeat (8) tick(1'b1, 1'b0, 32'h0);

        // Random traffic: grant, latency, decode stalls and redirects.
        gnt_rand = 1'b1; lat_min = 1; lat_max = 4;
        p0 = pops;
        for (int i = 0; i < 1500; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 29) == 0);
            tgt   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) == 0) tgt = tgt | 32'h2;
            tick(rdy, redir, tgt);
        end
        check("random_progress", (pops - p0) > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
